// File: rtl/score_ctrl.sv
// score_ctrl: two-team BCD scoreboard controller.
//   Four debounced buttons (A+1, A-1, B+1, B-1) queue actions as pending
//   flags. A fixed-priority arbiter applies one action per cycle to the
//   packed BCD score. The first team to reach WIN_SCORE ends the game. The
//   winner's digits then blink until clr starts a new game.
// Ports:
//   clk     system clock, all state on rising edge
//   rst     synchronous active-high reset, overrides everything
//   btn     raw buttons [0] A+1, [1] A-1, [2] B+1, [3] B-1
//   clr     synchronous level clear / new game (debouncers untouched)
//   num     BCD digits, [15:8] team A, [7:0] team B
//   blank   per-digit blank (1 = dark), [3:2] team A, [1:0] team B
//   point   per-digit decimal point (1 = lit)
//   over    game finished
//   winner  2'b01 team A, 2'b10 team B, 2'b00 none

// Per-button debouncer. The level follows raw only after raw has differed
// from it for DB_CYCLES consecutive samples. rise pulses for one cycle
// after each debounced 0->1 change.
module score_db #(
    parameter int DB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic rise
);
    localparam logic [19:0] DB_MAX = 20'(DB_CYCLES - 1);

    logic [19:0] cnt;
    logic        lvl;
    logic        lvl_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            lvl   <= 1'b0;
            lvl_d <= 1'b0;
        end else begin
            lvl_d <= lvl;
            if (raw == lvl) begin
                cnt <= '0;
            end else if (cnt == DB_MAX) begin
                lvl <= raw;
                cnt <= '0;
            end else begin
                cnt <= cnt + 20'd1;
            end
        end
    end

    assign rise = lvl & ~lvl_d;
endmodule

module score_ctrl #(
    parameter int         DB_CYCLES    = 500000,
    parameter int         BLINK_CYCLES = 25000000,
    parameter logic [7:0] WIN_SCORE    = 8'h21
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  btn,
    input  logic        clr,
    output logic [15:0] num,
    output logic [3:0]  blank,
    output logic [3:0]  point,
    output logic        over,
    output logic [1:0]  winner
);
    localparam int          NUM_BTN = 4;
    localparam logic [0:0]  S_PLAY  = 1'b0;
    localparam logic [0:0]  S_OVER  = 1'b1;
    localparam logic [24:0] BL_MAX  = 25'(BLINK_CYCLES - 1);

    logic [0:0]         state;
    logic [NUM_BTN-1:0] rise;
    logic [NUM_BTN-1:0] pending;
    logic [NUM_BTN-1:0] grant;
    logic [15:0]        num_nxt;
    logic               win_a;
    logic               win_b;
    logic [24:0]        blink_cnt;
    logic               blink;

    score_db #(.DB_CYCLES(DB_CYCLES)) u_db [NUM_BTN-1:0] (
        .clk  (clk),
        .rst  (rst),
        .raw  (btn),
        .rise (rise)
    );

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v == 8'h99)       return v;
        if (v[3:0] == 4'd9)   return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v == 8'h00)       return v;
        if (v[3:0] == 4'd0)   return {v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    // Lowest set pending bit wins; two's-complement isolates it.
    assign grant = (state == S_PLAY) ? (pending & (~pending + 4'd1)) : '0;

    always_comb begin
        num_nxt = num;
        case (grant)
            4'b0001: num_nxt[15:8] = bcd_inc(num[15:8]);
            4'b0010: num_nxt[15:8] = bcd_dec(num[15:8]);
            4'b0100: num_nxt[7:0]  = bcd_inc(num[7:0]);
            4'b1000: num_nxt[7:0]  = bcd_dec(num[7:0]);
            default: num_nxt = num;
        endcase
    end

    // Only the team that just acted can newly hit the winning score.
    assign win_a = (grant[0] | grant[1]) && (num_nxt[15:8] == WIN_SCORE);
    assign win_b = (grant[2] | grant[3]) && (num_nxt[7:0]  == WIN_SCORE);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state     <= S_PLAY;
            num       <= '0;
            pending   <= '0;
            winner    <= 2'b00;
            blink_cnt <= '0;
            blink     <= 1'b0;
        end else if (state == S_PLAY) begin
            // New rises merge into flags still waiting for the arbiter.
            pending   <= (pending & ~grant) | rise;
            num       <= num_nxt;
            blink_cnt <= '0;
            blink     <= 1'b0;
            if (win_a) begin
                state  <= S_OVER;
                winner <= 2'b01;
            end else if (win_b) begin
                state  <= S_OVER;
                winner <= 2'b10;
            end
        end else begin
            pending <= '0;
            if (blink_cnt == BL_MAX) begin
                blink_cnt <= '0;
                blink     <= ~blink;
            end else begin
                blink_cnt <= blink_cnt + 25'd1;
            end
        end
    end

    assign over  = (state == S_OVER);
    assign point = over ? 4'b0000 : 4'b0100;
    assign blank = !over     ? 4'b0000 :
                   winner[0] ? {blink, blink, 2'b00} :
                               {2'b00, blink, blink};
endmodule

// File: tb/tb_score_ctrl.sv
module tb_score_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  btn = 4'b0000;
    logic        clr = 1'b0;
    logic [15:0] num,    num2;
    logic [3:0]  blank,  blank2;
    logic [3:0]  point,  point2;
    logic        over,   over2;
    logic [1:0]  winner, winner2;
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    // Game ends at 03: used for timing, win, blink and clear checks.
    score_ctrl #(.DB_CYCLES(4), .BLINK_CYCLES(8), .WIN_SCORE(8'h03)) dut (
        .clk(clk), .rst(rst), .btn(btn), .clr(clr), .num(num),
        .blank(blank), .point(point), .over(over), .winner(winner)
    );

    // Unreachable win score so BCD carry/borrow/saturation can be exercised.
    score_ctrl #(.DB_CYCLES(4), .BLINK_CYCLES(8), .WIN_SCORE(8'hAA)) dut2 (
        .clk(clk), .rst(rst), .btn(btn), .clr(clr), .num(num2),
        .blank(blank2), .point(point2), .over(over2), .winner(winner2)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        btn = 4'b0000;
        clr = 1'b0;
        step(2);
        rst = 1'b0;
    endtask

    // Debounced press and release; action lands at the 6th edge.
    task automatic press(input int b);
        btn[b] = 1'b1;
        step(6);
        btn[b] = 1'b0;
        step(6);
    endtask

    initial begin
        do_reset();
        chk("rst_num",    num,    16'h0000);
        chk("rst_blank",  blank,  16'h0000);
        chk("rst_point",  point,  16'h0004);
        chk("rst_over",   over,   16'h0000);
        chk("rst_winner", winner, 16'h0000);

        // Single press: debounced rise at edge 4, score changes at edge 6.
        btn[0] = 1'b1;
        step(5);
        chk("press_e5", num, 16'h0000);
        step(1);
        chk("press_e6", num, 16'h0100);
        step(10);
        chk("press_hold", num, 16'h0100);
        btn[0] = 1'b0;
        step(6);

        // Three-cycle glitches never pass the debouncer.
        do_reset();
        repeat (3) begin
            btn[0] = 1'b1;
            step(3);
            btn[0] = 1'b0;
            step(2);
        end
        step(6);
        chk("glitch", num, 16'h0000);

        // Simultaneous rises are served one per cycle, A first.
        btn = 4'b0101;
        step(5);
        chk("both_e5", num, 16'h0000);
        step(1);
        chk("both_e6", num, 16'h0100);
        step(1);
        chk("both_e7", num, 16'h0101);
        btn = 4'b0000;
        step(6);

        // BCD arithmetic on the long game instance.
        do_reset();
        press(1);
        chk("dec_sat0", num2, 16'h0000);
        repeat (9) press(0);
        chk("inc_to09", num2, 16'h0900);
        press(0);
        chk("carry_10", num2, 16'h1000);
        press(1);
        chk("borrow_09", num2, 16'h0900);
        repeat (100) press(2);
        chk("sat_99", num2, 16'h0999);
        press(3);
        chk("dec_98", num2, 16'h0998);
        chk("dut2_over", over2, 16'h0000);

        // Win by team B and blink behaviour.
        do_reset();
        btn[2] = 1'b1; step(6); btn[2] = 1'b0; step(6);
        btn[2] = 1'b1; step(6); btn[2] = 1'b0; step(6);
        chk("pre_win", num, 16'h0002);
        chk("pre_win_over", over, 16'h0000);
        btn[2] = 1'b1;
        step(6);                      // game ends at this edge (X)
        chk("win_num",    num,    16'h0003);
        chk("win_over",   over,   16'h0001);
        chk("win_winner", winner, 16'h0002);
        chk("win_point",  point,  16'h0000);
        chk("win_blank0", blank,  16'h0000);
        btn[2] = 1'b0;
        step(7);                      // X+7
        chk("blink_x7",  blank, 16'h0000);
        step(1);                      // X+8
        chk("blink_x8",  blank, 16'h0003);
        step(7);                      // X+15
        chk("blink_x15", blank, 16'h0003);
        step(1);                      // X+16
        chk("blink_x16", blank, 16'h0000);
        press(0);
        press(3);
        chk("over_ignore", num, 16'h0003);
        chk("over_hold",   over, 16'h0001);

        // Clear starts a new game.
        clr = 1'b1;
        step(1);
        chk("clr_num",    num,    16'h0000);
        chk("clr_over",   over,   16'h0000);
        chk("clr_winner", winner, 16'h0000);
        chk("clr_point",  point,  16'h0004);
        chk("clr_blank",  blank,  16'h0000);
        // A press while clr is held is discarded.
        btn[0] = 1'b1;
        step(6);
        btn[0] = 1'b0;
        step(2);
        clr = 1'b0;
        step(8);
        chk("clr_held", num, 16'h0000);
        press(0);
        chk("clr_resume", num, 16'h0100);

        // Reset at the edge the debounced level would rise.
        do_reset();
        btn[0] = 1'b1;
        step(3);
        rst = 1'b1;
        step(1);
        btn[0] = 1'b0;
        rst = 1'b0;
        step(8);
        chk("rst_mid_db", num, 16'h0000);

        // Reset after the pending flag is set but before it is served.
        btn[0] = 1'b1;
        step(5);
        rst = 1'b1;
        btn[0] = 1'b0;
        step(1);
        rst = 1'b0;
        step(8);
        chk("rst_mid_pend", num, 16'h0000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/score_ctrl.md
SCORE_CTRL -- requirements
Module: score_ctrl

Interface
REQ-001 The block SHALL have parameter DB_CYCLES, default 500000, meaning consecutive stable cycles needed to accept a button level change (range 2..2^20-1).
REQ-002 The block SHALL have parameter BLINK_CYCLES, default 25000000, meaning half-period in cycles of the winner blink (range 2..2^25-1).
REQ-003 The block SHALL have parameter WIN_SCORE, default 8'h21, meaning the two-digit BCD score that ends a game.
REQ-004 clk  input  1  single system clock, all state on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 btn  input  4  raw buttons: [0] team A +1, [1] team A -1, [2] team B +1, [3] team B -1.
REQ-007 clr  input  1  synchronous level clear, starts a new game.
REQ-008 num  output 16  BCD digits for the display: [15:8] team A, [7:0] team B.
REQ-009 blank  output 4  per-digit blank, 1 = digit dark; [3:2] team A, [1:0] team B.
REQ-010 point  output 4  per-digit decimal point, 1 = lit.
REQ-011 over  output 1  1 while in state OVER.
REQ-012 winner  output 2  2'b01 team A won, 2'b10 team B won, 2'b00 no winner.

Function
REQ-013 Each btn bit SHALL have its own debouncer: counter clears whenever raw equals debounced level; else it increments; when it reaches DB_CYCLES-1 with raw still differing, debounced level takes raw at the next edge and the counter clears.
REQ-014 A 0->1 transition of a debounced level at edge E SHALL set pending[i] at edge E+1; falling transitions SHALL have no effect.
REQ-015 A rise on a bit whose pending flag is already set SHALL merge into that flag (one action).
REQ-016 Arbiter: at each edge in PLAY, the lowest-index set pending bit SHALL be cleared and its action applied to num at that edge (num changes at E+2); one action per cycle, others wait.
REQ-017 Score arithmetic SHALL be two-digit BCD: +1 carries 09->10, 99 saturates at 99; -1 borrows 10->09, 00 saturates at 00; the other team's byte is unchanged.
REQ-018 FSM states: PLAY, OVER; after reset state is PLAY.
REQ-019 PLAY->OVER SHALL occur at the same edge an action makes a team byte equal WIN_SCORE; winner latches 01 (A) or 10 (B) at that edge.
REQ-020 In OVER, btn actions SHALL be ignored and all pending flags held at 0; rises still update debouncers but set no pending.
REQ-021 In OVER, a blink counter SHALL run; the winner's two blank bits are 0 on entry and toggle each BLINK_CYCLES cycles; loser's blank bits stay 0.
REQ-022 In PLAY, blank SHALL be 4'b0000 and point SHALL be 4'b0100; in OVER, point SHALL be 4'b0000.
REQ-023 clr=1 at an edge SHALL force num=16'h0000, pending=0, winner=00, blank=0, blink counter=0, state PLAY; clr has priority over any arbiter action that cycle; debouncers unaffected.
REQ-024 clr held high SHALL keep the block in that cleared state; actions resume from the first edge with clr=0.
REQ-025 over SHALL equal (state==OVER) combinationally from the state register.

Reset
REQ-026 rst=1 at an edge SHALL set num=16'h0000, blank=4'b0000, point=4'b0100, over=0, winner=00, pending=0, all debounced levels=0, all counters=0, state PLAY.
REQ-027 rst SHALL override clr and all other inputs; reset mid-debounce or mid-blink SHALL abort that activity with no residual action.

Verification (DB_CYCLES=4, BLINK_CYCLES=8, WIN_SCORE=8'h03)
REQ-028 btn[0] high 4 cycles after reset -> num goes 16'h0000->16'h0100 exactly 2 edges after debounced rise; held longer -> no second increment.
REQ-029 btn[0] high 3 cycles then low, repeated -> num stays 16'h0000 (glitch rejected).
REQ-030 btn[0] and btn[2] rise same cycle -> num 16'h0100 at E+2, 16'h0101 at E+3.
REQ-031 btn[1] press at 16'h0000 -> 16'h0000; with A=8'h09, btn[0] press -> A=8'h10; with A=8'h10, btn[1] -> 8'h09.
REQ-032 Three btn[2] presses -> num 16'h0003, over=1, winner=10, blank[1:0] toggles 00/11 every 8 cycles, blank[3:2]=00, point=0000; further btn presses leave num unchanged.
REQ-033 clr=1 in OVER -> next edge num=16'h0000, over=0, winner=00, point=4'b0100; rst=1 during a btn debounce -> no increment after release of rst.
